alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one mini_alu instance between two requesters: port 0 (integer-unit issue) and port 1 (multi-cycle/microcode sequencer).
- Arbitrates, captures the granted operands, and registers the mini_alu result and flags into a single response slot with a valid/ready handshake.
- Sits between decode/issue and writeback; mini_alu is instantiated inside, and nothing else drives it.

Parameters:
- PRIO_FIXED, 0, 0 = round-robin between ports; 1 = port 0 always wins on conflict.
- DATA_W, 32, operand/result width; must equal the 32-bit mini_alu width; any other value is illegal (elaboration error).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- r0_valid  input  1  port 0 request valid
- r0_ready  output  1  port 0 request accepted this cycle
- r0_a  input  32  port 0 operand A
- r0_b  input  32  port 0 operand B
- r0_cin  input  1  port 0 carry-in
- r0_opcode  input  4  port 0 mini_alu opcode
- r1_valid, r1_ready, r1_a, r1_b, r1_cin, r1_opcode  same as port 0, for port 1
- rsp_valid  output  1  response slot holds a result
- rsp_ready  input  1  consumer takes the response this cycle
- rsp_id  output  1  requester that owns the response (0/1)
- rsp_y  output  32  registered mini_alu y
- rsp_flags  output  4  registered mini_alu flags

Behaviour:
- Reset (synchronous, active-high; clock `clk`, reset `reset`):
  - rsp_valid=0, rsp_id=0, rsp_y=0, rsp_flags=0.
  - last_grant=1, so port 0 wins the first conflict.
  - r0_ready=r1_ready=0 during the reset cycle.
- State machine:
  - IDLE: slot empty.
  - FULL: slot holds an unconsumed result.
- Accept condition `can_accept` = (state==IDLE) | (state==FULL & rsp_ready). Back-to-back operation gives one op per cycle.
- Grant, evaluated only when can_accept:
  - Exactly one valid request: that port is granted.
  - Both valid and PRIO_FIXED=0: grant the port != last_grant.
  - Both valid and PRIO_FIXED=1: grant port 0.
  - Neither valid: no grant.
- rN_ready = can_accept & grant==N (combinational). At most one ready is high per cycle, and never while reset is high.
- Handshake: a request transfers on rN_valid & rN_ready.
  - Requesters hold operands stable while valid and not ready.
  - The block does not buffer ungranted requests.
- Datapath:
  - mini_alu inputs are muxed from the granted port; the port 0 inputs are selected when idle (don't-care).
  - Result is registered on the accepting edge, so latency is 1 cycle: accepted in cycle N gives rsp_valid=1 in N+1.
- Transitions:
  - On accept: state→FULL, rsp_id=grant, rsp_y/rsp_flags load, last_grant=grant.
  - FULL & rsp_ready & no new accept: state→IDLE, rsp_valid→0. rsp_y/flags hold their old values.
  - FULL & !rsp_ready: all rsp_* stable, both readies 0 (backpressure).
- last_grant updates only on a transfer. A lone requester does not starve the other: an alternate conflict always flips.
- Reset mid-operation: the held result is discarded and the reset values above apply the next cycle. Requesters must reissue.
- Flags are passed unmodified from mini_alu; no flag merging across ops.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each) plus conflict_cnt (16 bits).
  - These count transfers per port and cycles where both valid and can_accept.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and their counters do not exist. Functional behaviour is identical either way.

Decomposition:
- Package alu_pkg:
  - ALU_W=32, ALU_OP_W=4, ALU_FLAG_W=4.
  - Opcode constants, including ALU_OP_ADD=4'b0000.
  - Typedef alu_req_t {a, b, cin, opcode}.
  - Flag bit indices N=3, Z=2, V=1, C=0.
- One natural sub-module: alu_rr_pick (2-way grant logic, with PRIO_FIXED and last_grant input).
- mini_alu is reused as-is.

Test Plan:
- Single request: after reset, r0 ADD a=1, b=3, cin=0 → r0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_y=32'h4, flags=4'b0000.
- Conflict round-robin: r0 and r1 both valid for 4 cycles with rsp_ready=1 → grants 0,1,0,1 and rsp_id alternates each cycle.
- Backpressure: r1 accepted, rsp_ready=0 for 3 cycles → rsp_y/rsp_id stable, r0_ready=r1_ready=0; rsp_ready=1 → same-cycle accept of pending r0.
- Fixed priority: PRIO_FIXED=1, both valid continuously → only port 0 granted; r1_ready stays 0.
- Zero/carry flags: ADD a=32'hFFFFFFFF, b=1 → rsp_y=0, flags Z=1 and C=1.
- Reset mid-op: reset asserted while FULL → next cycle rsp_valid=0, rsp_y=0. With ALU_ARB_STATS_EN, counters=0 and grant_cnt0 saturates at 16'hFFFF after 65536+ grants.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcodes, flag indices, the request bundle type and
// the response-slot state encoding for the mini_alu sharing arbiter.
package alu_pkg;

  localparam int unsigned ALU_W      = 32;
  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned ALU_FLAG_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND   = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR    = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR   = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_PASSB = 4'b0101;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef struct packed {
    logic [ALU_W-1:0]    a;
    logic [ALU_W-1:0]    b;
    logic                cin;
    logic [ALU_OP_W-1:0] opcode;
  } alu_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: 2-way grant selection.
//   req0, req1  : request valids
//   last_grant  : port granted on the most recent transfer
//   gnt_valid   : some request is present
//   gnt         : granted port (0 when nothing is requested)
// PRIO_FIXED=0 alternates on conflict, PRIO_FIXED=1 always favours port 0.
module alu_rr_pick #(
  parameter int PRIO_FIXED = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt       = 1'b0;
    if (req0 && req1) begin
      gnt = (PRIO_FIXED != 0) ? 1'b0 : ~last_grant;
    end else if (req1) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/mini_alu.sv
// mini_alu: 32-bit combinational ALU.
//   a, b, cin, opcode -> y, flags {N,Z,V,C}
//   ADD: a+b+cin; SUB: a+~b+cin (cin=1 for a plain subtract, C = no-borrow);
//   AND/OR/XOR/PASSB are logical, V=C=0. Unknown opcodes give y=0.
module mini_alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0]      a,
  input  logic [ALU_W-1:0]      b,
  input  logic                  cin,
  input  logic [ALU_OP_W-1:0]   opcode,
  output logic [ALU_W-1:0]      y,
  output logic [ALU_FLAG_W-1:0] flags
);

  logic [ALU_W:0] sum;
  logic           v;
  logic           c;

  always_comb begin
    sum = '0;
    y   = '0;
    v   = 1'b0;
    c   = 1'b0;
    case (opcode)
      ALU_OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b} + {{ALU_W{1'b0}}, cin};
        y   = sum[ALU_W-1:0];
        c   = sum[ALU_W];
        v   = (a[ALU_W-1] == b[ALU_W-1]) && (y[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_OP_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, cin};
        y   = sum[ALU_W-1:0];
        c   = sum[ALU_W];
        v   = (a[ALU_W-1] != b[ALU_W-1]) && (y[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_OP_AND:   y = a & b;
      ALU_OP_OR:    y = a | b;
      ALU_OP_XOR:   y = a ^ b;
      ALU_OP_PASSB: y = b;
      default:      y = '0;
    endcase
    flags         = '0;
    flags[FLAG_N] = y[ALU_W-1];
    flags[FLAG_Z] = (y == '0);
    flags[FLAG_V] = v;
    flags[FLAG_C] = c;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one mini_alu between port 0 (integer issue) and
// port 1 (microcode sequencer), registering the result into a single
// valid/ready response slot (1-cycle latency, one op per cycle sustained).
//   clk, reset (sync, active-high)
//   r0_*/r1_* : valid/ready request ports with a, b, cin, opcode
//   rsp_*     : valid/ready response with owner id, y and flags {N,Z,V,C}
// Optional feature macro ALU_ARB_STATS_EN adds saturating 16-bit counters
// grant_cnt0, grant_cnt1 (transfers per port) and conflict_cnt (cycles with
// both ports valid while the slot could accept).
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int PRIO_FIXED = 0,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [DATA_W-1:0]     r0_a,
  input  logic [DATA_W-1:0]     r0_b,
  input  logic                  r0_cin,
  input  logic [ALU_OP_W-1:0]   r0_opcode,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [DATA_W-1:0]     r1_a,
  input  logic [DATA_W-1:0]     r1_b,
  input  logic                  r1_cin,
  input  logic [ALU_OP_W-1:0]   r1_opcode,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_W-1:0]     rsp_y,
  output logic [ALU_FLAG_W-1:0] rsp_flags
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]           grant_cnt0,
  output logic [15:0]           grant_cnt1,
  output logic [15:0]           conflict_cnt
`endif
);

  if (DATA_W != ALU_W) begin : g_bad_width
    $error("alu_share_arbiter: DATA_W must equal the mini_alu width");
  end

  arb_state_t            state_q, state_d;
  logic                  last_grant_q;
  logic                  can_accept;
  logic                  pick_valid;
  logic                  pick;
  logic                  accept;
  alu_req_t              req0, req1, req_sel;
  logic [ALU_W-1:0]      alu_y;
  logic [ALU_FLAG_W-1:0] alu_flags;

  assign req0 = '{a: r0_a, b: r0_b, cin: r0_cin, opcode: r0_opcode};
  assign req1 = '{a: r1_a, b: r1_b, cin: r1_cin, opcode: r1_opcode};

  alu_rr_pick #(
    .PRIO_FIXED(PRIO_FIXED)
  ) u_pick (
    .req0      (r0_valid),
    .req1      (r1_valid),
    .last_grant(last_grant_q),
    .gnt_valid (pick_valid),
    .gnt       (pick)
  );

  // pick is 0 when nobody requests, so port 0 feeds the ALU while idle.
  assign req_sel = pick ? req1 : req0;

  mini_alu u_alu (
    .a     (req_sel.a),
    .b     (req_sel.b),
    .cin   (req_sel.cin),
    .opcode(req_sel.opcode),
    .y     (alu_y),
    .flags (alu_flags)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept)         state_d = ST_FULL;
        else if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / handshake logic. Readies are masked by reset so nothing is
  // accepted during the reset cycle.
  always_comb begin
    rsp_valid  = (state_q == ST_FULL);
    can_accept = (state_q == ST_IDLE) || ((state_q == ST_FULL) && rsp_ready);
    accept     = can_accept && pick_valid && !reset;
    r0_ready   = accept && (pick == 1'b0);
    r1_ready   = accept && (pick == 1'b1);
  end

  // Response slot and arbitration history; y/flags hold when the slot drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rsp_id       <= 1'b0;
      rsp_y        <= '0;
      rsp_flags    <= '0;
    end else if (accept) begin
      last_grant_q <= pick;
      rsp_id       <= pick;
      rsp_y        <= alu_y;
      rsp_flags    <= alu_flags;
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (r0_valid && r0_ready && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (r1_valid && r1_ready && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 16'd1;
      if (r0_valid && r1_valid && can_accept && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scoreboard bench for alu_share_arbiter,
// one round-robin instance and one fixed-priority instance.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        r0_valid = 1'b0, r1_valid = 1'b0, rsp_ready = 1'b0;
  logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic        r0_cin = 1'b0, r1_cin = 1'b0;
  logic [3:0]  r0_op = '0, r1_op = '0;
  logic        r0_ready, r1_ready, rsp_valid, rsp_id;
  logic [31:0] rsp_y;
  logic [3:0]  rsp_flags;

  logic        f0_valid = 1'b0, f1_valid = 1'b0, f_rsp_ready = 1'b0;
  logic [31:0] f0_a = '0, f0_b = '0, f1_a = '0, f1_b = '0;
  logic        f0_ready, f1_ready, f_rsp_valid, f_rsp_id;
  logic [31:0] f_rsp_y;
  logic [3:0]  f_rsp_flags;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] gc0, gc1, cc, f_gc0, f_gc1, f_cc;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        id;
    logic [31:0] y;
    logic [3:0]  flags;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.PRIO_FIXED(0), .DATA_W(32)) u_rr (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_cin(r0_cin), .r0_opcode(r0_op),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_cin(r1_cin), .r1_opcode(r1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(gc0), .grant_cnt1(gc1), .conflict_cnt(cc)
`endif
  );

  alu_share_arbiter #(.PRIO_FIXED(1), .DATA_W(32)) u_fx (
    .clk(clk), .reset(reset),
    .r0_valid(f0_valid), .r0_ready(f0_ready), .r0_a(f0_a), .r0_b(f0_b),
    .r0_cin(1'b0), .r0_opcode(4'b0000),
    .r1_valid(f1_valid), .r1_ready(f1_ready), .r1_a(f1_a), .r1_b(f1_b),
    .r1_cin(1'b0), .r1_opcode(4'b0000),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id),
    .rsp_y(f_rsp_y), .rsp_flags(f_rsp_flags)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(f_gc0), .grant_cnt1(f_gc1), .conflict_cnt(f_cc)
`endif
  );

  // Reference ALU: flags are {N, Z, V, C}.
  function automatic exp_t model(input logic id, input logic [31:0] a,
                                 input logic [31:0] b, input logic cin,
                                 input logic [3:0] op);
    exp_t        e;
    logic [32:0] s;
    logic        v, c;
    e.id = id;
    v = 1'b0;
    c = 1'b0;
    s = '0;
    case (op)
      4'b0000: begin
        s = {1'b0, a} + {1'b0, b} + 33'(cin);
        e.y = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (e.y[31] != a[31]);
      end
      4'b0001: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'(cin);
        e.y = s[31:0];
        c = s[32];
        v = (a[31] != b[31]) && (e.y[31] != a[31]);
      end
      4'b0100: e.y = a ^ b;
      default: e.y = '0;
    endcase
    e.flags = {e.y[31], (e.y == 32'd0), v, c};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the round-robin instance: check readies and the response
  // slot at the falling edge, update the scoreboard, then advance.
  task automatic step(input logic e0, input logic e1);
    @(negedge clk);
    chk("r0_ready", r0_ready, e0);
    chk("r1_ready", r1_ready, e1);
    chk("rsp_valid", rsp_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("rsp_id", rsp_id, q[0].id);
      chk("rsp_y", rsp_y, q[0].y);
      chk("rsp_flags", rsp_flags, q[0].flags);
      if (rsp_ready) void'(q.pop_front());
    end
    if (r0_valid && e0) q.push_back(model(1'b0, r0_a, r0_b, r0_cin, r0_op));
    if (r1_valid && e1) q.push_back(model(1'b1, r1_a, r1_b, r1_cin, r1_op));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: readies stay low even with a request pending.
    @(posedge clk); #1;
    r0_valid = 1'b1; r0_a = 32'd5; f0_valid = 1'b1;
    @(negedge clk);
    chk("reset_r0_ready", r0_ready, 1'b0);
    chk("reset_r1_ready", r1_ready, 1'b0);
    chk("reset_f0_ready", f0_ready, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_id", rsp_id, 1'b0);
    chk("reset_rsp_y", rsp_y, 32'd0);
    chk("reset_rsp_flags", rsp_flags, 4'd0);
`ifdef ALU_ARB_STATS_EN
    chk("reset_gc0", gc0, 16'd0);
    chk("reset_gc1", gc1, 16'd0);
    chk("reset_cc", cc, 16'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0; f0_valid = 1'b0;

    // Single request: ADD 1+3.
    r0_a = 32'd1; r0_b = 32'd3; r0_cin = 1'b0; r0_op = 4'b0000; rsp_ready = 1'b1;
    step(1'b1, 1'b0);
    r0_valid = 1'b0;
    chk("single_y_direct", rsp_y, 32'h4);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Conflict round-robin from a fresh reset: grants 0,1,0,1.
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_a = 32'd10; r0_b = 32'd1; r0_op = 4'b0000;
    r1_a = 32'd100; r1_b = 32'd2; r1_op = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step((i % 2) == 0, (i % 2) == 1);
      if ((i % 2) == 0) r0_a = r0_a + 32'd1;
      else              r1_a = r1_a + 32'd1;
    end
`ifdef ALU_ARB_STATS_EN
    chk("stats_gc0", gc0, 16'd2);
    chk("stats_gc1", gc1, 16'd2);
    chk("stats_cc", cc, 16'd4);
`endif

    // Backpressure: r1 SUB accepted, slot held for 3 cycles, then r0 XOR
    // is accepted in the same cycle the held result drains.
    r0_valid = 1'b0;
    r1_a = 32'h1234; r1_b = 32'd4; r1_cin = 1'b1; r1_op = 4'b0001;
    step(1'b0, 1'b1);
    r1_valid = 1'b0; r1_cin = 1'b0; rsp_ready = 1'b0;
    r0_valid = 1'b1; r0_a = 32'h7; r0_b = 32'h8; r0_op = 4'b0100;
    repeat (3) step(1'b0, 1'b0);
    rsp_ready = 1'b1;
    step(1'b1, 1'b0);
    r0_valid = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Zero/carry and negative/overflow flags.
    r0_valid = 1'b1; r0_a = 32'hFFFF_FFFF; r0_b = 32'd1; r0_op = 4'b0000;
    step(1'b1, 1'b0);
    chk("zc_y", rsp_y, 32'd0);
    chk("zc_flags", rsp_flags, 4'b0101);
    r0_a = 32'h7FFF_FFFF;
    step(1'b1, 1'b0);
    r0_valid = 1'b0;
    chk("nv_y", rsp_y, 32'h8000_0000);
    chk("nv_flags", rsp_flags, 4'b1010);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Reset while FULL discards the held result.
    r1_valid = 1'b1; r1_a = 32'd2; r1_b = 32'd2; r1_op = 4'b0000;
    step(1'b0, 1'b1);
    r1_valid = 1'b0; rsp_ready = 1'b0; reset = 1'b1;
    step(1'b0, 1'b0);
    q.delete();
    chk("midreset_rsp_valid", rsp_valid, 1'b0);
    chk("midreset_rsp_y", rsp_y, 32'd0);
    chk("midreset_rsp_flags", rsp_flags, 4'd0);
    chk("midreset_rsp_id", rsp_id, 1'b0);
    reset = 1'b0;
    rsp_ready = 1'b1;

    // Fixed priority: port 0 always wins, port 1 never gets ready.
    f0_valid = 1'b1; f1_valid = 1'b1; f_rsp_ready = 1'b1;
    f0_a = 32'd20; f0_b = 32'd22; f1_a = 32'd1; f1_b = 32'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fixed_f0_ready", f0_ready, 1'b1);
      chk("fixed_f1_ready", f1_ready, 1'b0);
      if (i > 0) begin
        chk("fixed_rsp_valid", f_rsp_valid, 1'b1);
        chk("fixed_rsp_id", f_rsp_id, 1'b0);
        chk("fixed_rsp_y", f_rsp_y, 32'd42);
      end
      @(posedge clk); #1;
    end
    f0_valid = 1'b0; f1_valid = 1'b0;

`ifdef ALU_ARB_STATS_EN
    // Saturation: more than 65535 port-0 transfers.
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    r0_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd1; r0_op = 4'b0000;
    repeat (65540) @(posedge clk);
    #1;
    r0_valid = 1'b0;
    chk("sat_gc0", gc0, 16'hFFFF);
    chk("sat_gc1", gc1, 16'd0);
    chk("sat_cc", cc, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
